// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetched {pc, instr} entries with synchronous clear and
// combinational head read.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  input  logic                          push_i,
  input  fetch_entry_t                  entry_i,
  input  logic                          pop_i,
  output fetch_entry_t                  head_o,
  output logic [cnt_width(DEPTH)-1:0]   count_o
);

  localparam int unsigned CW = cnt_width(DEPTH);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (clear_i) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (push_i) wr_d = bump(wr_q);
      if (pop_i)  rd_d = bump(rd_q);
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) mem_q[wr_q] <= entry_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues credit-limited requests
// to instruction memory and presents queued words to the decode register.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned      QDEPTH   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  output logic [WIDTH-1:0] PCF,
  output logic [WIDTH-1:0] instrF,
  output logic [WIDTH-1:0] PCPlus4F,
  output logic             validF
);

  localparam int unsigned CW = cnt_width(QDEPTH);

  logic [WIDTH-1:0] req_pc_q, req_pc_d, rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]    out_q, out_d, drop_q, drop_d;
  logic [CW-1:0]    q_count;
  logic [CW:0]      inflight;
  fetch_entry_t     q_head, push_entry;
  logic             rsp_fire, keep, req_fire, pop;

  // Credits count words in flight plus words queued, so a push never meets a full queue.
  assign inflight       = {1'b0, out_q} + {1'b0, q_count};
  assign imem_req_valid = rst_n && !redirect && (inflight < (CW + 1)'(QDEPTH));
  assign imem_req_addr  = req_pc_q;

  assign rsp_fire   = imem_rsp_valid && (out_q != '0);
  assign keep       = rsp_fire && (drop_q == '0) && !redirect;
  assign req_fire   = imem_req_valid && imem_req_ready;
  assign pop        = validF && !stall && !redirect;
  assign push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};

  always_comb begin
    out_d    = out_q + CW'(req_fire) - CW'(rsp_fire);
    drop_d   = drop_q;
    req_pc_d = req_pc_q;
    rsp_pc_d = rsp_pc_q;
    if (redirect) begin
      drop_d   = out_q - CW'(rsp_fire);
      req_pc_d = redirect_pc;
      rsp_pc_d = redirect_pc;
    end else begin
      if (rsp_fire && (drop_q != '0)) drop_d = drop_q - 1'b1;
      if (req_fire) req_pc_d = req_pc_q + WIDTH'(4);
      if (keep)     rsp_pc_d = rsp_pc_q + WIDTH'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_pc_q <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
    end else begin
      req_pc_q <= req_pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
    end
  end

  fetch_queue #(
    .DEPTH(QDEPTH)
  ) u_queue (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clear_i (redirect),
    .push_i  (keep),
    .entry_i (push_entry),
    .pop_i   (pop),
    .head_o  (q_head),
    .count_o (q_count)
  );

  assign validF   = (q_count != '0);
  assign instrF   = validF ? q_head.instr : NOP;
  assign PCF      = validF ? q_head.pc : '0;
  assign PCPlus4F = validF ? q_head.pc + WIDTH'(4) : '0;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined core. It owns the fetch PC and issues sequential requests to instruction memory over a valid/ready request channel with in-order responses, buffering returned words in a small queue. It presents PCF, instrF and PCPlus4F to the fetch-to-decode pipeline register and accepts a taken-branch/jump redirect from execute. It honours the hazard unit's fetch stall.

## Interface
- WIDTH, 32: address/data width.
- RESET_PC, 32'h0000_0000: first PC fetched after reset.
- QDEPTH, 3: entries in the instruction queue; also the cap on outstanding plus queued fetches.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  StallF from the hazard unit; holds the presented instruction.
- redirect  in  1  PCSrcE; discard all fetched and in-flight work and restart at redirect_pc.
- redirect_pc  in  WIDTH  PCTargetE.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  WIDTH  fetch address.
- imem_rsp_valid  in  1  response word valid; in order, no backpressure, latency ≥1 cycle.
- imem_rsp_data  in  WIDTH  instruction word.
- PCF  out  WIDTH  PC of the presented instruction.
- instrF  out  WIDTH  presented instruction.
- PCPlus4F  out  WIDTH  PCF+4.
- validF  out  1  the F outputs carry a real instruction.

## Operation
- State: req_pc, outstanding counter, drop counter, queue of {pc, instr}. Counter widths are $clog2(QDEPTH+1).
- Issue: imem_req_valid = !redirect && (outstanding + count < QDEPTH), using registered values only; there is no combinational path from stall. imem_req_addr = req_pc.
- Acceptance (valid && ready): req_pc += 4 and outstanding += 1.
- Response: outstanding -= 1.
  - If drop > 0: drop -= 1 and the word is discarded.
  - Otherwise push {pc, data}. The queue pc is tracked by a separate rsp_pc register that advances by 4 per kept response.
  - A response arriving while outstanding == 0 is ignored.
- Presentation:
  - Queue non-empty: validF = 1 and the head is shown.
  - Queue empty: validF = 0, instrF = 32'h0000_0013 (NOP), PCF = 0, PCPlus4F = 0.
- Pop: validF && !stall && !redirect. Pop and push in the same cycle are legal, and count is unchanged.
- Redirect (highest priority):
  - Queue cleared.
  - req_pc and rsp_pc ← redirect_pc.
  - drop ← outstanding minus any response discarded this cycle.
  - No request is issued in the redirect cycle.
  - A response arriving in the redirect cycle is discarded.
  - Redirect overrides stall in the same cycle.
- An unaccepted request may change address only on redirect. The memory treats an abandoned request as never issued.
- Arithmetic: PC+4 is modulo 2^WIDTH, so 0xFFFF_FFFC wraps to 0. redirect_pc is used unmodified.

## Timing
- Reset (asynchronous, any time): req_pc = rsp_pc = RESET_PC; outstanding = drop = count = 0. Outputs: validF 0, instrF 0x13, PCF 0, PCPlus4F 0, imem_req_valid 0 while rst_n is low.
- First cycle after reset release: request at RESET_PC.
- With 1-cycle memory and ready high, validF first rises 2 cycles after release. Throughput is one instruction per cycle at QDEPTH=3.
- Redirect in cycle t: request at redirect_pc in t+1. With 1-cycle memory, validF with PCF = redirect_pc in t+3.
- Stall: F outputs are stable for the whole stall. Requests continue until credits are exhausted.
- Full queue: issue stops. The credit rule guarantees no response ever arrives to a full queue.

## Structure
- fetch_pkg:
  - NOP constant 32'h0000_0013.
  - fetch_entry_t struct {pc, instr}.
  - Counter width helper.
- Sub-module fetch_queue: parameterised-depth FIFO of fetch_entry_t with push, pop, synchronous clear, count and combinational head read.
- fetch_stage instantiates fetch_queue and holds the counters and PCs.

## Test plan
- Reset, then 1-cycle memory with ready=1 and stall=0 → from cycle 2, PCF = 0x0, 0x4, 0x8… one per cycle with no gaps; PCPlus4F = PCF+4.
- Stall for 4 cycles mid-stream → PCF/instrF frozen. imem_req_valid drops once outstanding+count=3. After release the sequence resumes with no duplicates and no skips.
- 3-cycle memory latency with 2 fetches outstanding, then redirect to 0x100 → both stale responses dropped. The next validF shows PCF=0x100 with the word at 0x100.
- imem_req_ready low for 5 cycles → imem_req_addr stable. validF falls to 0 once the queue drains, and instrF=0x13, PCF=0.
- Redirect and stall asserted together, and redirect coinciding with a response → redirect wins, the queue is empty next cycle and the response is discarded.
- rst_n pulsed low mid-run with fetches outstanding → all outputs at reset values immediately (asynchronously). After release, fetch restarts at RESET_PC and late responses are ignored. Wrap check: redirect to 0xFFFF_FFFC → next PCF 0x0.
